// File: rtl/logic16_pkg.sv
// Shared types and constants for the logic16 arbiter slice.
package logic16_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_NOT = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin winner search, purely combinational.
module rr_arbiter4
  import logic16_pkg::*;
(
  input  logic [NREQ-1:0] request,
  input  logic [1:0]      last_grant,
  output logic            any,
  output logic [1:0]      grant
);

  logic [1:0] idx;
  logic       found;

  // Scan last_grant+1 .. last_grant+4 (mod 4); the first active request wins.
  always_comb begin
    any   = |request;
    grant = last_grant;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = last_grant + 2'(i);
      if (!found && request[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbitrated bitwise logic unit: grant, execute, respond.
module logic16_arbiter
  import logic16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  input  logic [2*NREQ-1:0]      req_op,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_id,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   busy,
  output logic [15:0]            op_count
);

  state_e           state, state_nxt;
  logic [1:0]       last_grant;
  logic [1:0]       grant;
  logic             any;
  logic             accept;
  logic [1:0]       cap_id;
  logic [WIDTH-1:0] cap_a, cap_b;
  op_e              cap_op;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] resp_data_q;
  logic [15:0]      op_count_q;

  rr_arbiter4 u_rr (
    .request    (req_valid),
    .last_grant (last_grant),
    .any        (any),
    .grant      (grant)
  );

  // Grant is offered only in IDLE; gating with rst_n keeps req_ready low while reset is held.
  always_comb begin
    accept    = rst_n && (state == IDLE) && any;
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bitwise operation on the captured operands.
  always_comb begin
    result = '0;
    case (cap_op)
      OP_AND:  result = cap_a & cap_b;
      OP_OR:   result = cap_a | cap_b;
      OP_NOT:  result = ~cap_a;
      OP_XOR:  result = cap_a ^ cap_b;
      default: result = '0;
    endcase
  end

  // Operand capture, result register, completion bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a       <= '0;
      cap_b       <= '0;
      cap_op      <= OP_AND;
      cap_id      <= '0;
      resp_data_q <= '0;
      op_count_q  <= '0;
      last_grant  <= 2'd3;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cap_a  <= req_a[grant*WIDTH +: WIDTH];
          cap_b  <= req_b[grant*WIDTH +: WIDTH];
          cap_op <= op_e'(req_op[grant*2 +: 2]);
          cap_id <= grant;
        end
        EXEC: resp_data_q <= result;
        RESP: if (resp_ready) begin
          op_count_q <= op_count_q + 16'd1;
          last_grant <= cap_id;
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    resp_valid = (state == RESP);
    resp_id    = cap_id;
    resp_data  = resp_data_q;
    busy       = (state != IDLE);
    op_count   = op_count_q;
  end

endmodule
